// File: rtl/seu_count_readout.sv
// Reader side of the triplicated SEU counter: snapshots the free-running count, reports the
// events since the previous snapshot and a saturating running total over a valid/ready handshake.
module seu_count_readout #(
   parameter int unsigned SEUCNTWIDTH = 8,
   parameter int unsigned ACCWIDTH    = 16,
   parameter int unsigned PERIOD      = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SEUCNTWIDTH-1:0] seuCount,
   output logic                   seuCountRst,
   input  logic                   req,
   input  logic                   clr,
   output logic                   valid,
   input  logic                   ready,
   output logic [SEUCNTWIDTH-1:0] delta,
   output logic [ACCWIDTH-1:0]    total,
   output logic                   overflow
);

   localparam int unsigned TIMERWIDTH = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned TIMERLAST  = (PERIOD > 0) ? PERIOD - 1 : 0;
   localparam int unsigned SUMWIDTH   = ACCWIDTH + 1;

   typedef enum logic [1:0] {CLEAR, IDLE, SAMPLE, PRESENT} stateType;

   stateType               state;
   logic                   clrCnt;
   logic                   pending;
   logic [SEUCNTWIDTH-1:0] last;
   logic [TIMERWIDTH-1:0]  timer;

   logic                   timerExpire;
   logic [SEUCNTWIDTH-1:0] deltaNew;
   logic [SUMWIDTH-1:0]    sumWide;

   // Modulo subtraction gives the right event count across a single counter wrap.
   always_comb begin
      timerExpire = (PERIOD != 0) && (state != CLEAR) && (timer == TIMERWIDTH'(TIMERLAST));
      deltaNew    = seuCount - last;
      sumWide     = {1'b0, total} + SUMWIDTH'(deltaNew);
   end

   // NOTE: all state here uses non-blocking assignments so every branch reads pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state       <= CLEAR;
         clrCnt      <= 1'b0;
         seuCountRst <= 1'b1;
         valid       <= 1'b0;
         total       <= '0;
         overflow    <= 1'b0;
         last        <= '0;
         pending     <= 1'b0;
         timer       <= '0;
         if (rst) delta <= '0;
      end else begin
         if (state == CLEAR || PERIOD == 0 || timerExpire) timer <= '0;
         else                                              timer <= timer + TIMERWIDTH'(1);

         // A new request on the edge that leaves IDLE is kept for a following snapshot.
         if (state != CLEAR) begin
            if (req || timerExpire) pending <= 1'b1;
            else if (state == IDLE) pending <= 1'b0;
         end

         case (state)
            CLEAR: begin
               seuCountRst <= 1'b0;
               clrCnt      <= 1'b1;
               if (clrCnt) begin
                  clrCnt <= 1'b0;
                  state  <= IDLE;
               end
            end
            IDLE: begin
               if (pending) state <= SAMPLE;
            end
            SAMPLE: begin
               delta <= deltaNew;
               last  <= seuCount;
               if (sumWide[ACCWIDTH]) begin
                  total    <= '1;
                  overflow <= 1'b1;
               end else begin
                  total <= sumWide[ACCWIDTH-1:0];
               end
               valid <= 1'b1;
               state <= PRESENT;
            end
            PRESENT: begin
               if (ready) begin
                  valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_seu_count_readout.sv
// Scoreboard bench: dutA (no auto-snapshot) covers reset, handshake, wrap, saturation and clr;
// dutB (PERIOD=16) covers the timer and request coalescing.
module tb_seu_count_readout;

   typedef struct packed {
      logic [7:0]  d;
      logic [15:0] t;
      logic        o;
   } recType;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rstB;
   logic [7:0]  seuCountA, seuCountB;
   logic        seuCountRstA, seuCountRstB;
   logic        reqA, reqB, clrA, clrB, readyA, readyB;
   logic        validA, validB, overflowA, overflowB;
   logic [7:0]  deltaA, deltaB;
   logic [15:0] totalA, totalB;

   int checks = 0;
   int errors = 0;
   recType qA[$];
   recType qB[$];

   seu_count_readout #(.SEUCNTWIDTH(8), .ACCWIDTH(16), .PERIOD(0)) dutA (
      .clk(clk), .rst(rst), .seuCount(seuCountA), .seuCountRst(seuCountRstA),
      .req(reqA), .clr(clrA), .valid(validA), .ready(readyA),
      .delta(deltaA), .total(totalA), .overflow(overflowA));

   seu_count_readout #(.SEUCNTWIDTH(8), .ACCWIDTH(16), .PERIOD(16)) dutB (
      .clk(clk), .rst(rstB), .seuCount(seuCountB), .seuCountRst(seuCountRstB),
      .req(reqB), .clr(clrB), .valid(validB), .ready(readyB),
      .delta(deltaB), .total(totalB), .overflow(overflowB));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Records are compared as they are accepted; a record dropped by clr is never accepted.
   always @(negedge clk) begin
      recType e;
      if (!rst && validA && readyA && !clrA) begin
         if (qA.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_record: unexpected record delta=%0d total=%0d", deltaA, totalA);
         end else begin
            e = qA.pop_front();
            check("a_delta", 32'(deltaA), 32'(e.d));
            check("a_total", 32'(totalA), 32'(e.t));
            check("a_overflow", 32'(overflowA), 32'(e.o));
         end
      end
   end

   always @(negedge clk) begin
      recType e;
      if (!rstB && validB && readyB && !clrB) begin
         if (qB.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_record: unexpected record delta=%0d total=%0d", deltaB, totalB);
         end else begin
            e = qB.pop_front();
            check("b_delta", 32'(deltaB), 32'(e.d));
            check("b_total", 32'(totalB), 32'(e.t));
            check("b_overflow", 32'(overflowB), 32'(e.o));
         end
      end
   end

   task automatic snapA(input logic [7:0] cnt, input recType exp);
      int n;
      seuCountA = cnt;
      qA.push_back(exp);
      reqA = 1'b1;
      tick();
      reqA = 1'b0;
      n = 0;
      while (!validA && n < 8) begin
         tick();
         n++;
      end
      check("a_snap_valid", 32'(validA), 1);
      readyA = 1'b1;
      tick();
      readyA = 1'b0;
   endtask

   initial begin
      logic [7:0]  cur;
      logic [15:0] expTot;
      int          n, stableBad, extra;

      rst = 1'b1; rstB = 1'b1;
      seuCountA = '0; seuCountB = '0;
      reqA = 1'b0; reqB = 1'b0; clrA = 1'b0; clrB = 1'b0;
      readyA = 1'b0; readyB = 1'b0;

      // Reset state and the release sequence of CLEAR
      repeat (3) tick();
      check("rst_seuCountRst", 32'(seuCountRstA), 1);
      check("rst_valid", 32'(validA), 0);
      check("rst_total", 32'(totalA), 0);
      check("rst_overflow", 32'(overflowA), 0);
      check("rst_delta", 32'(deltaA), 0);
      rst = 1'b0;
      tick();
      check("clear_pulse_end", 32'(seuCountRstA), 0);
      tick();
      check("clear_done_rst", 32'(seuCountRstA), 0);
      check("clear_done_valid", 32'(validA), 0);

      // First snapshot: latency, hold under back-pressure, acceptance
      seuCountA = 8'd5;
      qA.push_back(recType'{8'd5, 16'd5, 1'b0});
      reqA = 1'b1;
      tick();
      reqA = 1'b0;
      tick();
      check("lat_not_yet", 32'(validA), 0);
      tick();
      check("lat_valid", 32'(validA), 1);
      check("lat_delta", 32'(deltaA), 5);
      check("lat_total", 32'(totalA), 5);
      repeat (3) begin
         tick();
         check("hold_valid", 32'(validA), 1);
         check("hold_delta", 32'(deltaA), 5);
         check("hold_total", 32'(totalA), 5);
      end
      readyA = 1'b1;
      tick();
      readyA = 1'b0;
      check("accept_valid_low", 32'(validA), 0);

      // Wrap of the monitored counter
      snapA(8'd250, recType'{8'd245, 16'd250, 1'b0});
      snapA(8'd4, recType'{8'd10, 16'd260, 1'b0});

      // Drive total to 65530 in steps of 255, then saturate
      cur = 8'd4;
      expTot = 16'd260;
      for (int i = 0; i < 255; i++) begin
         cur = cur + 8'd255;
         expTot = expTot + 16'd255;
         snapA(cur, recType'{8'd255, expTot, 1'b0});
      end
      cur = cur + 8'd245;
      snapA(cur, recType'{8'd245, 16'd65530, 1'b0});
      check("pre_sat_total", 32'(totalA), 65530);
      check("pre_sat_overflow", 32'(overflowA), 0);
      cur = cur + 8'd10;
      snapA(cur, recType'{8'd10, 16'd65535, 1'b1});
      check("sat_total", 32'(totalA), 65535);
      check("sat_overflow", 32'(overflowA), 1);
      cur = cur + 8'd3;
      snapA(cur, recType'{8'd3, 16'd65535, 1'b1});
      check("sat_hold_total", 32'(totalA), 65535);
      check("sat_hold_overflow", 32'(overflowA), 1);

      // clr while a record is presented and ready is high: record is dropped
      cur = cur + 8'd7;
      seuCountA = cur;
      reqA = 1'b1;
      tick();
      reqA = 1'b0;
      n = 0;
      while (!validA && n < 8) begin
         tick();
         n++;
      end
      check("clr_pre_valid", 32'(validA), 1);
      clrA = 1'b1;
      readyA = 1'b1;
      tick();
      clrA = 1'b0;
      readyA = 1'b0;
      check("clr_valid", 32'(validA), 0);
      check("clr_seuCountRst", 32'(seuCountRstA), 1);
      check("clr_total", 32'(totalA), 0);
      check("clr_overflow", 32'(overflowA), 0);
      tick();
      check("clr_pulse_end", 32'(seuCountRstA), 0);
      tick();
      seuCountA = 8'd0;
      snapA(8'd6, recType'{8'd6, 16'd6, 1'b0});

      // Auto-snapshot every 16 cycles and coalescing while the record is held
      rstB = 1'b0;
      seuCountB = 8'd3;
      qB.push_back(recType'{8'd3, 16'd3, 1'b0});
      repeat (19) tick();
      check("b_auto_early", 32'(validB), 0);
      tick();
      check("b_auto_first", 32'(validB), 1);
      seuCountB = 8'd9;
      stableBad = 0;
      for (int i = 0; i < 40; i++) begin
         reqB = (i == 5 || i == 20 || i == 21);
         tick();
         if (!validB || deltaB !== 8'd3 || totalB !== 16'd3) stableBad++;
      end
      reqB = 1'b0;
      check("b_hold_stable", 32'(stableBad), 0);
      qB.push_back(recType'{8'd6, 16'd9, 1'b0});
      readyB = 1'b1;
      tick();
      check("b_accept_low", 32'(validB), 0);
      tick();
      tick();
      check("b_extra_valid", 32'(validB), 1);
      tick();
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         if (validB) extra++;
         if (i < 3) tick();
      end
      check("b_single_extra", 32'(extra), 0);
      qB.push_back(recType'{8'd0, 16'd9, 1'b0});
      tick();
      check("b_next_auto", 32'(validB), 1);
      tick();
      readyB = 1'b0;
      check("b_next_accepted", 32'(validB), 0);

      check("a_queue_empty", 32'(qA.size()), 0);
      check("b_queue_empty", 32'(qB.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
